// File: rtl/fsm_sym_decoder_pkg.sv
// Shared definitions for the 4-state serial symbol codec: state encoding and
// the receive-side decode table (state, symbol) -> {legal, bit, next state}.
package fsm_sym_decoder_pkg;

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_e;

   typedef struct packed {
      logic   legal;
      logic   dbit;
      state_e next;
   } dec_t;

   // Every state has exactly one symbol meaning '1' and one meaning '0';
   // anything else is illegal and leaves the result at its cleared default.
   function automatic dec_t decode(input state_e st, input logic [1:0] sym);
      dec_t       d;
      logic [1:0] one_sym;
      logic [1:0] zero_sym;
      state_e     one_next;
      state_e     zero_next;
      d.legal   = 1'b0;
      d.dbit    = 1'b0;
      d.next    = S0;
      one_sym   = 2'd1;
      zero_sym  = 2'd0;
      one_next  = S1;
      zero_next = S0;
      case (st)
         S0: begin one_sym = 2'd1; one_next = S1; zero_sym = 2'd0; zero_next = S0; end
         S1: begin one_sym = 2'd2; one_next = S3; zero_sym = 2'd0; zero_next = S2; end
         S2: begin one_sym = 2'd0; one_next = S3; zero_sym = 2'd1; zero_next = S2; end
         S3: begin one_sym = 2'd0; one_next = S0; zero_sym = 2'd1; zero_next = S1; end
         default: begin one_sym = 2'd1; one_next = S1; zero_sym = 2'd0; zero_next = S0; end
      endcase
      if (sym == one_sym) begin
         d.legal = 1'b1;
         d.dbit  = 1'b1;
         d.next  = one_next;
      end else if (sym == zero_sym) begin
         d.legal = 1'b1;
         d.dbit  = 1'b0;
         d.next  = zero_next;
      end
      return d;
   endfunction

endpackage

// File: rtl/fsm_sym_decoder_if.sv
// Symbol-in / word-out bundle of the symbol decoder. The master side feeds
// symbols and resync requests; the slave side (decoder) returns bits, words, errors.
interface fsm_sym_decoder_if #(
   parameter int WORD_W    = 8,
   parameter int ERR_CNT_W = 8
);
   logic [1:0]           sym_in;
   logic                 sym_valid;
   logic                 sync_clr;
   logic                 bit_out;
   logic                 bit_valid;
   logic [WORD_W-1:0]    word_out;
   logic                 word_valid;
   logic                 err;
   logic [ERR_CNT_W-1:0] err_cnt;

   modport master (
      output sym_in, sym_valid, sync_clr,
      input  bit_out, bit_valid, word_out, word_valid, err, err_cnt
   );

   modport slave (
      input  sym_in, sym_valid, sync_clr,
      output bit_out, bit_valid, word_out, word_valid, err, err_cnt
   );
endinterface

// File: rtl/fsm_sym_decoder_deser.sv
// Bit-to-word deserialiser: first bit shifted in ends up in the word MSB;
// clr drops any partial word without touching the last completed word.
module fsm_sym_deser #(
   parameter int WORD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en_i,
   input  logic              bit_i,
   input  logic              clr_i,
   output logic [WORD_W-1:0] word_o,
   output logic              word_valid_o
);
   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

   logic [WORD_W-2:0] shreg_q;
   logic [WORD_W-1:0] shift_d;
   logic [IDX_W-1:0]  bit_idx_q;
   logic [WORD_W-1:0] word_q;
   logic              word_valid_q;

   assign shift_d = {shreg_q, bit_i};

   // The shift register is not cleared on clr: bit_idx restarting at 0
   // guarantees every stale bit is shifted out before the next word completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q      <= '0;
         bit_idx_q    <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else begin
         word_valid_q <= 1'b0;
         if (clr_i) begin
            bit_idx_q <= '0;
         end else if (shift_en_i) begin
            shreg_q <= shift_d[WORD_W-2:0];
            if (bit_idx_q == LAST_IDX) begin
               word_q       <= shift_d;
               word_valid_q <= 1'b1;
               bit_idx_q    <= '0;
            end else begin
               bit_idx_q <= bit_idx_q + 1'b1;
            end
         end
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = word_valid_q;
endmodule

// File: rtl/fsm_sym_decoder.sv
// Receive-side symbol decoder: tracks the encoder's 4-state Mealy FSM, recovers
// one bit per legal symbol, flags/counts illegal symbols and resyncs to S0.
module fsm_sym_decoder
   import fsm_sym_decoder_pkg::*;
#(
   parameter int WORD_W    = 8,
   parameter int ERR_CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   fsm_sym_decoder_if.slave  bus
);
   state_e               state_q;
   logic                 bit_out_q;
   logic                 bit_valid_q;
   logic                 err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   dec_t                 dec_d;
   logic                 accept;
   logic                 shift_en;
   logic                 deser_clr;
   logic [WORD_W-1:0]    word;
   logic                 word_valid;

   assign dec_d     = decode(state_q, bus.sym_in);
   // sync_clr swallows any symbol presented in the same cycle.
   assign accept    = bus.sym_valid & ~bus.sync_clr;
   assign shift_en  = accept & dec_d.legal;
   assign deser_clr = bus.sync_clr | (accept & ~dec_d.legal);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S0;
         bit_out_q   <= 1'b0;
         bit_valid_q <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         bit_valid_q <= 1'b0;
         err_q       <= 1'b0;
         if (bus.sync_clr) begin
            state_q <= S0;
         end else if (bus.sym_valid) begin
            if (dec_d.legal) begin
               state_q     <= dec_d.next;
               bit_out_q   <= dec_d.dbit;
               bit_valid_q <= 1'b1;
            end else begin
               state_q <= S0;
               err_q   <= 1'b1;
               if (err_cnt_q != '1) begin
                  err_cnt_q <= err_cnt_q + 1'b1;
               end
            end
         end
      end
   end

   fsm_sym_deser #(
      .WORD_W (WORD_W)
   ) u_deser (
      .clk          (clk),
      .rst          (rst),
      .shift_en_i   (shift_en),
      .bit_i        (dec_d.dbit),
      .clr_i        (deser_clr),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   assign bus.bit_out    = bit_out_q;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.word_out   = word;
   assign bus.word_valid = word_valid;
   assign bus.err        = err_q;
   assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_fsm_sym_decoder.sv
// Directed bench for fsm_sym_decoder: a vector table of per-cycle inputs and
// expected outputs, plus a hand sequence for the narrow saturating counter.
module tb_fsm_sym_decoder;
   import fsm_sym_decoder_pkg::*;

   typedef struct packed {
      logic       r;
      logic [1:0] sym;
      logic       v;
      logic       c;
      logic       bv;
      logic       bo;
      logic       wv;
      logic [7:0] word;
      logic       err;
      logic [7:0] cnt;
      logic [1:0] st;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fsm_sym_decoder_if #(.WORD_W(8), .ERR_CNT_W(8)) bus8();
   fsm_sym_decoder_if #(.WORD_W(8), .ERR_CNT_W(2)) bus2();

   fsm_sym_decoder #(.WORD_W(8), .ERR_CNT_W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   fsm_sym_decoder #(.WORD_W(8), .ERR_CNT_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[$];

   logic [1:0] seq_sym [8];
   logic       seq_bit [8];
   logic [1:0] seq_st  [8];

   function void add(int r, int sym, int v, int c, int bv, int bo, int wv,
                     int word, int err, int cnt, int st);
      vec_t t;
      t.r    = 1'(r);
      t.sym  = 2'(sym);
      t.v    = 1'(v);
      t.c    = 1'(c);
      t.bv   = 1'(bv);
      t.bo   = 1'(bo);
      t.wv   = 1'(wv);
      t.word = 8'(word);
      t.err  = 1'(err);
      t.cnt  = 8'(cnt);
      t.st   = 2'(st);
      vecs.push_back(t);
   endfunction

   // Sequence 1,0,0,0,0,0,1,0 from S0 with an empty partial word -> 8'hB2.
   function void push_seq2(int prev_word, int cnt, bit gaps);
      int w;
      for (int i = 0; i < 8; i++) begin
         w = (i == 7) ? 32'hB2 : prev_word;
         add(0, int'(seq_sym[i]), 1, 0, 1, int'(seq_bit[i]), (i == 7) ? 1 : 0,
             w, 0, cnt, int'(seq_st[i]));
         if (gaps) begin
            add(0, 3, 0, 0, 0, int'(seq_bit[i]), 0, w, 0, cnt, int'(seq_st[i]));
         end
      end
   endfunction

   task automatic cyc(input logic r, input logic [1:0] s, input logic v, input logic c);
      @(negedge clk);
      rst            = r;
      bus8.sym_in    = s;
      bus8.sym_valid = v;
      bus8.sync_clr  = c;
      bus2.sym_in    = s;
      bus2.sym_valid = v;
      bus2.sync_clr  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int i);
      vec_t        t;
      logic [1:0]  st_act;
      logic [21:0] act;
      logic [21:0] exp;
      t = vecs[i];
      cyc(t.r, t.sym, t.v, t.c);
      st_act = dut8.state_q;
      act = {bus8.bit_valid, bus8.bit_out, bus8.word_valid, bus8.word_out,
             bus8.err, bus8.err_cnt, st_act};
      exp = {t.bv, t.bo, t.wv, t.word, t.err, t.cnt, t.st};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL vec%0d r=%0d sym=%0d v=%0d c=%0d: got bv=%0d bo=%0d wv=%0d word=%02h err=%0d cnt=%0d st=%0d expected bv=%0d bo=%0d wv=%0d word=%02h err=%0d cnt=%0d st=%0d",
                  i, t.r, t.sym, t.v, t.c,
                  bus8.bit_valid, bus8.bit_out, bus8.word_valid, bus8.word_out,
                  bus8.err, bus8.err_cnt, st_act,
                  t.bv, t.bo, t.wv, t.word, t.err, t.cnt, t.st);
      end else begin
         $display("[TB] vec%0d r=%0d sym=%0d v=%0d c=%0d -> bv=%0d bo=%0d wv=%0d word=%02h err=%0d cnt=%0d st=%0d ok",
                  i, t.r, t.sym, t.v, t.c, t.bv, t.bo, t.wv, t.word, t.err, t.cnt, t.st);
      end
   endtask

   initial begin
      int pulses;
      int exp_cnt;

      bus8.sym_in = 2'd0; bus8.sym_valid = 1'b0; bus8.sync_clr = 1'b0;
      bus2.sym_in = 2'd0; bus2.sym_valid = 1'b0; bus2.sync_clr = 1'b0;

      seq_sym = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
      seq_bit = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      seq_st  = '{S1, S2, S3, S0, S0, S0, S1, S2};

      // Basic decode: 1,2,1,2 -> bits 1,1,0,1 ending in S3
      add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, S0);
      add(0, 1, 1, 0, 1, 1, 0, 8'h00, 0, 0, S1);
      add(0, 2, 1, 0, 1, 1, 0, 8'h00, 0, 0, S3);
      add(0, 1, 1, 0, 1, 0, 0, 8'h00, 0, 0, S1);
      add(0, 2, 1, 0, 1, 1, 0, 8'h00, 0, 0, S3);

      // Full word from reset
      add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, S0);
      push_seq2(0, 0, 1'b0);

      // Illegal symbols: first in S0, then sym 2 in S2 after three legal bits
      add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, S0);
      add(0, 3, 1, 0, 0, 0, 0, 8'h00, 1, 1, S0);
      add(0, 1, 1, 0, 1, 1, 0, 8'h00, 0, 1, S1);
      add(0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 1, S2);
      add(0, 1, 1, 0, 1, 0, 0, 8'h00, 0, 1, S2);
      add(0, 2, 1, 0, 0, 0, 0, 8'h00, 1, 2, S0);
      push_seq2(0, 2, 1'b0);

      // Same word with idle cycles (an illegal symbol with sym_valid low) between
      add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, S0);
      push_seq2(0, 0, 1'b1);

      // sync_clr mid-word, together with sym_valid, then alone in S0
      add(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, S0);
      add(0, 1, 1, 0, 1, 1, 0, 8'h00, 0, 0, S1);
      add(0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 0, S2);
      add(0, 0, 1, 0, 1, 1, 0, 8'h00, 0, 0, S3);
      add(0, 0, 1, 1, 0, 1, 0, 8'h00, 0, 0, S0);
      add(0, 0, 0, 1, 0, 1, 0, 8'h00, 0, 0, S0);
      push_seq2(0, 0, 1'b0);

      // Illegal keeps word_out, then rst after 4 bits beats a valid symbol
      add(0, 3, 1, 0, 0, 0, 0, 8'hB2, 1, 1, S0);
      add(0, 1, 1, 0, 1, 1, 0, 8'hB2, 0, 1, S1);
      add(0, 0, 1, 0, 1, 0, 0, 8'hB2, 0, 1, S2);
      add(0, 0, 1, 0, 1, 1, 0, 8'hB2, 0, 1, S3);
      add(0, 0, 1, 0, 1, 1, 0, 8'hB2, 0, 1, S0);
      add(1, 1, 1, 0, 0, 0, 0, 8'h00, 0, 0, S0);
      push_seq2(0, 0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(i);
      end

      // Saturation of the 2-bit counter over five illegal symbols
      cyc(1'b1, 2'd0, 1'b0, 1'b0);
      chk("rst_cnt2", 32'(bus2.err_cnt), 32'd0);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 2'd3, 1'b1, 1'b0);
         exp_cnt = (i < 3) ? i + 1 : 3;
         if (bus2.err === 1'b1) pulses++;
         chk("sat_cnt2", 32'(bus2.err_cnt), 32'(exp_cnt));
         chk("sat_bv2", 32'(bus2.bit_valid), 32'd0);
         chk("cnt8", 32'(bus8.err_cnt), 32'(i + 1));
         $display("[TB] illegal#%0d err=%0d cnt2=%0d cnt8=%0d",
                  i, bus2.err, bus2.err_cnt, bus8.err_cnt);
      end
      chk("sat_pulses", 32'(pulses), 32'd5);
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
      chk("sat_idle_err", 32'(bus2.err), 32'd0);
      chk("sat_hold", 32'(bus2.err_cnt), 32'd3);
      // sync_clr must not touch the error count
      cyc(1'b0, 2'd3, 1'b1, 1'b1);
      chk("clr_err", 32'(bus2.err), 32'd0);
      chk("clr_cnt8", 32'(bus8.err_cnt), 32'd5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
